// File: rtl/deser_bitslip_align_ctrl.sv
// Word-alignment sequencer for a bank of ISERDES channels: serves one channel at a time,
// bitslipping it until its word matches the latched training pattern CHECK_LEN times in a row.
module deser_bitslip_align_ctrl #(
    parameter  int NCH       = 4,
    parameter  int DESERF    = 8,
    parameter  int SETTLE    = 4,
    parameter  int CHECK_LEN = 8,
    parameter  int MAX_SLIPS = 16,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int SCW       = $clog2(MAX_SLIPS + 1)
) (
    input  logic                  GCLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [DESERF-1:0]     TRAIN_PATTERN,
    input  logic [NCH*DESERF-1:0] DATAIN,
    output logic [NCH-1:0]        DESERSYNC,
    output logic [NCH-1:0]        ALIGNED,
    output logic [NCH-1:0]        FAILED,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [CHW-1:0]        CUR_CH,
    output logic [SCW-1:0]        SLIP_CNT
);

    localparam int STW = $clog2(SETTLE + 1);
    localparam int MCW = $clog2(CHECK_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_CHECK, S_SLIP, S_NEXT, S_FIN
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [DESERF-1:0]         r_pattern;
    logic [NCH-1:0]            r_desersync, r_aligned, r_failed;
    logic                      r_busy, r_done;
    logic [CHW-1:0]            r_cur_ch;
    logic [SCW-1:0]            r_slip_cnt;
    logic [STW-1:0]            r_settle;
    logic [MCW-1:0]            r_match;

    logic [NCH-1:0][DESERF-1:0] w_words;
    logic [NCH-1:0]            w_lane_match;
    logic [NCH-1:0]            w_cur_onehot;
    logic                      w_cur_match;
    logic                      w_settle_done, w_qual_done, w_budget_left, w_last_ch;

    assign w_words = DATAIN;

    // Every lane compares in parallel; the channel in service picks its result.
    for (genvar k = 0; k < NCH; k++) begin : g_lane
        assign w_lane_match[k] = (w_words[k] == r_pattern);
    end

    always_comb begin
        w_cur_onehot = '0;
        w_cur_match  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (r_cur_ch == CHW'(k)) begin
                w_cur_onehot[k] = 1'b1;
                w_cur_match     = w_lane_match[k];
            end
        end
    end

    assign w_settle_done = (r_settle == STW'(SETTLE - 1));
    assign w_qual_done   = (r_match == MCW'(CHECK_LEN - 1));
    assign w_budget_left = (r_slip_cnt != SCW'(MAX_SLIPS));
    assign w_last_ch     = (r_cur_ch == CHW'(NCH - 1));

    always_ff @(posedge GCLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_FIN: if (START) w_state_nxt = S_WAIT;
            S_WAIT:        if (w_settle_done) w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (w_cur_match) begin
                    if (w_qual_done) w_state_nxt = S_NEXT;
                end else if (w_budget_left) begin
                    w_state_nxt = S_SLIP;
                end else begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_SLIP:        w_state_nxt = S_WAIT;
            S_NEXT:        w_state_nxt = w_last_ch ? S_FIN : S_WAIT;
            default:       w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge GCLK) begin
        if (RESET) begin
            r_pattern   <= '0;
            r_desersync <= '0;
            r_aligned   <= '0;
            r_failed    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cur_ch    <= '0;
            r_slip_cnt  <= '0;
            r_settle    <= '0;
            r_match     <= '0;
        end else begin
            // The bitslip strobe is a one-cycle pulse issued on entry to SLIP.
            r_desersync <= '0;
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (START) begin
                        r_pattern  <= TRAIN_PATTERN;
                        r_aligned  <= '0;
                        r_failed   <= '0;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_cur_ch   <= '0;
                        r_slip_cnt <= '0;
                        r_settle   <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_settle_done) r_match  <= '0;
                    else               r_settle <= r_settle + 1'b1;
                end
                S_CHECK: begin
                    if (w_cur_match) begin
                        r_match <= r_match + 1'b1;
                        if (w_qual_done) r_aligned <= r_aligned | w_cur_onehot;
                    end else if (w_budget_left) begin
                        r_desersync <= w_cur_onehot;
                        r_slip_cnt  <= r_slip_cnt + 1'b1;
                    end else begin
                        r_failed <= r_failed | w_cur_onehot;
                    end
                end
                S_SLIP: r_settle <= '0;
                S_NEXT: begin
                    if (w_last_ch) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_cur_ch   <= r_cur_ch + 1'b1;
                        r_slip_cnt <= '0;
                        r_settle   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign DESERSYNC = r_desersync;
    assign ALIGNED   = r_aligned;
    assign FAILED    = r_failed;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign CUR_CH    = r_cur_ch;
    assign SLIP_CNT  = r_slip_cnt;

endmodule

// File: tb/tb_deser_bitslip_align_ctrl.sv
// Bench for deser_bitslip_align_ctrl: a one-channel and a four-channel instance driven by
// rotating-word channel models, checked every cycle against a procedural sweep model.
module tb_deser_bitslip_align_ctrl;

    localparam int SETTLE = 4;
    localparam int CL     = 8;
    localparam int MS     = 16;

    logic        GCLK = 1'b0;
    logic        RESET;
    logic [7:0]  pat, base;
    logic        st1, st4;
    logic [7:0]  din1;
    logic [31:0] din4;

    logic        ds1, al1, fl1, by1, dn1, cc1;
    logic [4:0]  sc1;
    logic [3:0]  ds4, al4, fl4;
    logic        by4, dn4;
    logic [1:0]  cc4;
    logic [4:0]  sc4;

    always #5 GCLK = ~GCLK;

    deser_bitslip_align_ctrl #(.NCH(1)) u1 (
        .GCLK(GCLK), .RESET(RESET), .START(st1), .TRAIN_PATTERN(pat), .DATAIN(din1),
        .DESERSYNC(ds1), .ALIGNED(al1), .FAILED(fl1), .BUSY(by1), .DONE(dn1),
        .CUR_CH(cc1), .SLIP_CNT(sc1));

    deser_bitslip_align_ctrl #(.NCH(4)) u4 (
        .GCLK(GCLK), .RESET(RESET), .START(st4), .TRAIN_PATTERN(pat), .DATAIN(din4),
        .DESERSYNC(ds4), .ALIGNED(al4), .FAILED(fl4), .BUSY(by4), .DONE(dn4),
        .CUR_CH(cc4), .SLIP_CNT(sc4));

    int cyc_n = 0;
    always @(posedge GCLK) cyc_n <= cyc_n + 1;

    // ---------------- channel models (owned by the stimulus process) ----------------
    int off [2][4];
    bit cz  [2][4];
    bit gl  [2][4];
    bit hold[2][4];

    function automatic logic [7:0] rotl8(input logic [7:0] w, input int n);
        logic [7:0] r;
        r = w;
        for (int i = 0; i < n % 8; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic drive();
        logic [7:0] w;
        for (int id = 0; id < 2; id++) begin
            for (int k = 0; k < 4; k++) begin
                w = cz[id][k] ? 8'h00 : rotl8(base, off[id][k]);
                if (gl[id][k]) w = ~w;
                if (id == 0 && k == 0) din1 = w;
                else if (id == 1)      din4[k*8 +: 8] = w;
            end
        end
    endtask

    // ---------------- behavioural model of a sweep ----------------
    logic [15:0] e_sync[2], e_al[2], e_fl[2];
    bit          e_busy[2], e_done[2];
    int          e_cur[2], e_slip[2];

    function automatic bit m_start(input int id);
        return (id == 0) ? st1 : st4;
    endfunction

    function automatic logic [7:0] m_word(input int id, input int ch);
        return (id == 0) ? din1 : din4[ch*8 +: 8];
    endfunction

    task automatic m_clear(input int id);
        e_sync[id] = '0; e_al[id] = '0; e_fl[id] = '0;
        e_busy[id] = 0; e_done[id] = 0; e_cur[id] = 0; e_slip[id] = 0;
    endtask

    task automatic m_edge(input int id, output bit ab);
        @(posedge GCLK);
        e_sync[id] = '0;
        ab = RESET;
        if (ab) m_clear(id);
    endtask

    task automatic m_sweep(input int id, input int nch);
        bit         ab;
        logic [7:0] p;
        int         run, slips, res;
        p = pat;
        e_al[id] = '0; e_fl[id] = '0; e_done[id] = 0; e_busy[id] = 1;
        e_cur[id] = 0; e_slip[id] = 0;
        for (int ch = 0; ch < nch; ch++) begin
            slips = 0;
            forever begin
                repeat (SETTLE) begin m_edge(id, ab); if (ab) return; end
                run = 0; res = 0;
                while (res == 0) begin
                    m_edge(id, ab); if (ab) return;
                    if (m_word(id, ch) == p) begin
                        run++;
                        if (run == CL) res = 1;
                    end else res = 2;
                end
                if (res == 1) begin e_al[id][ch] = 1'b1; break; end
                if (slips == MS) begin e_fl[id][ch] = 1'b1; break; end
                slips++;
                e_slip[id] = slips;
                e_sync[id][ch] = 1'b1;
                m_edge(id, ab); if (ab) return;
            end
            m_edge(id, ab); if (ab) return;
            if (ch == nch - 1) begin e_busy[id] = 0; e_done[id] = 1; end
            else begin e_cur[id] = ch + 1; e_slip[id] = 0; end
        end
    endtask

    task automatic m_run(input int id, input int nch);
        bit ab;
        m_clear(id);
        forever begin
            m_edge(id, ab);
            if (!ab && m_start(id)) m_sweep(id, nch);
        end
    endtask

    initial fork
        m_run(0, 1);
        m_run(1, 4);
    join

    // ---------------- checking ----------------
    int checks = 0, errors = 0;
    int t0[2], done_rel[2];
    int pul1[$];
    int cnt4;
    bit pdn[2];
    logic pds1;
    logic [3:0] pds4;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc_n);
        end
    endtask

    task automatic compare();
        chk("u1.DESERSYNC", 32'(ds1), 32'(e_sync[0][0]));
        chk("u1.ALIGNED",   32'(al1), 32'(e_al[0][0]));
        chk("u1.FAILED",    32'(fl1), 32'(e_fl[0][0]));
        chk("u1.BUSY",      32'(by1), 32'(e_busy[0]));
        chk("u1.DONE",      32'(dn1), 32'(e_done[0]));
        chk("u1.CUR_CH",    32'(cc1), e_cur[0]);
        chk("u1.SLIP_CNT",  32'(sc1), e_slip[0]);
        chk("u4.DESERSYNC", 32'(ds4), 32'(e_sync[1][3:0]));
        chk("u4.ALIGNED",   32'(al4), 32'(e_al[1][3:0]));
        chk("u4.FAILED",    32'(fl4), 32'(e_fl[1][3:0]));
        chk("u4.BUSY",      32'(by4), 32'(e_busy[1]));
        chk("u4.DONE",      32'(dn4), 32'(e_done[1]));
        chk("u4.CUR_CH",    32'(cc4), e_cur[1]);
        chk("u4.SLIP_CNT",  32'(sc4), e_slip[1]);
        chk("u4.pulse_off_cur", 32'(ds4 & ~(4'b0001 << cc4)), 32'd0);
        chk("u1.pulse_b2b", 32'(ds1 & pds1), 32'd0);
        chk("u4.pulse_b2b", 32'(ds4 & pds4), 32'd0);
        chk("u4.excl", 32'(al4 & fl4), 32'd0);
        if (ds1) pul1.push_back(cyc_n - t0[0]);
        if (|ds4) cnt4++;
        if (dn1 && !pdn[0]) done_rel[0] = cyc_n - t0[0];
        if (dn4 && !pdn[1]) done_rel[1] = cyc_n - t0[1];
        pdn[0] = dn1; pdn[1] = dn4; pds1 = ds1; pds4 = ds4;
    endtask

    task automatic cyc();
        @(negedge GCLK);
        compare();
        if (ds1 && !hold[0][0]) off[0][0] = (off[0][0] + 7) % 8;
        for (int k = 0; k < 4; k++)
            if (ds4[k] && !hold[1][k]) off[1][k] = (off[1][k] + 7) % 8;
        drive();
    endtask

    task automatic start(input int id);
        pul1.delete(); cnt4 = 0; done_rel[id] = -1;
        if (id == 0) st1 = 1'b1; else st4 = 1'b1;
        cyc();
        t0[id] = cyc_n;
        st1 = 1'b0; st4 = 1'b0;
    endtask

    task automatic wait_done(input int id, input int budget);
        int n;
        n = 0;
        while (!((id == 0) ? dn1 : dn4) && n < budget) begin cyc(); n++; end
        chk("done_seen", 32'((id == 0) ? dn1 : dn4), 32'd1);
    endtask

    initial begin
        RESET = 1'b1; st1 = 1'b0; st4 = 1'b0;
        pat = 8'h5C; base = 8'h5C;
        pds1 = 1'b0; pds4 = '0; pdn[0] = 0; pdn[1] = 0; cnt4 = 0;
        for (int id = 0; id < 2; id++)
            for (int k = 0; k < 4; k++) begin
                off[id][k] = 0; cz[id][k] = 0; gl[id][k] = 0; hold[id][k] = 0;
            end
        drive();
        @(negedge GCLK);
        repeat (3) cyc();
        chk("reset.u1.DONE", 32'(dn1), 32'd0);
        chk("reset.u4.BUSY", 32'(by4), 32'd0);
        RESET = 1'b0;
        cyc();

        // already aligned at entry
        start(0);
        wait_done(0, 200);
        chk("aligned.latency", done_rel[0], 13);
        chk("aligned.pulses", pul1.size(), 0);
        chk("aligned.ALIGNED", 32'(al1), 32'd1);
        chk("aligned.FAILED", 32'(fl1), 32'd0);
        repeat (2) cyc();

        // three slips needed
        off[0][0] = 3; drive();
        start(0);
        wait_done(0, 300);
        chk("slip.pulses", pul1.size(), 3);
        if (pul1.size() == 3) begin
            chk("slip.p0", pul1[0], 5);
            chk("slip.p1", pul1[1], 11);
            chk("slip.p2", pul1[2], 17);
        end
        chk("slip.latency", done_rel[0], 31);
        chk("slip.SLIP_CNT", 32'(sc1), 32'd3);
        chk("slip.ALIGNED", 32'(al1), 32'd1);
        repeat (2) cyc();

        // unalignable channel exhausts the budget
        cz[0][0] = 1; drive();
        start(0);
        wait_done(0, 400);
        chk("budget.pulses", pul1.size(), 16);
        if (pul1.size() == 16) chk("budget.last_pulse", pul1[15], 95);
        chk("budget.latency", done_rel[0], 102);
        chk("budget.FAILED", 32'(fl1), 32'd1);
        chk("budget.ALIGNED", 32'(al1), 32'd0);
        chk("budget.SLIP_CNT", 32'(sc1), 32'd16);
        repeat (4) cyc();
        chk("budget.no_17th", pul1.size(), 16);
        cz[0][0] = 0; off[0][0] = 0; drive();

        // one corrupted word after five matches
        hold[0][0] = 1;
        start(0);
        repeat (9) cyc();
        gl[0][0] = 1; drive();
        cyc();
        gl[0][0] = 0; drive();
        wait_done(0, 300);
        chk("glitch.pulses", pul1.size(), 1);
        if (pul1.size() == 1) chk("glitch.p0", pul1[0], 10);
        chk("glitch.latency", done_rel[0], 24);
        chk("glitch.ALIGNED", 32'(al1), 32'd1);
        chk("glitch.SLIP_CNT", 32'(sc1), 32'd1);
        hold[0][0] = 0;
        repeat (2) cyc();

        // four-channel sweep: offsets 0, 2, unalignable, 5
        off[1][0] = 0; off[1][1] = 2; cz[1][2] = 1; off[1][3] = 5; drive();
        start(1);
        wait_done(1, 1000);
        chk("multi.ALIGNED", 32'(al4), 32'hB);
        chk("multi.FAILED", 32'(fl4), 32'h4);
        chk("multi.latency", done_rel[1], 183);
        chk("multi.pulses", cnt4, 23);
        chk("multi.CUR_CH", 32'(cc4), 32'd3);
        chk("multi.SLIP_CNT", 32'(sc4), 32'd5);
        repeat (2) cyc();

        // START while busy must be ignored
        start(1);
        repeat (3) cyc();
        st4 = 1'b1; cyc(); st4 = 1'b0;
        wait_done(1, 1000);
        chk("abuse.latency", done_rel[1], 141);
        chk("abuse.pulses", cnt4, 16);
        chk("abuse.ALIGNED", 32'(al4), 32'hB);
        repeat (2) cyc();

        // reset during the SLIP cycle, then a full new sweep
        off[0][0] = 3; drive();
        start(0);
        repeat (5) cyc();
        chk("rst.slip_cycle", 32'(ds1), 32'd1);
        RESET = 1'b1;
        cyc();
        chk("rst.DESERSYNC", 32'(ds1), 32'd0);
        chk("rst.BUSY", 32'(by1), 32'd0);
        chk("rst.SLIP_CNT", 32'(sc1), 32'd0);
        chk("rst.u4.ALIGNED", 32'(al4), 32'd0);
        RESET = 1'b0;
        cyc();
        start(0);
        wait_done(0, 300);
        chk("rst.resweep.latency", done_rel[0], 25);
        chk("rst.resweep.SLIP_CNT", 32'(sc1), 32'd2);
        chk("rst.resweep.ALIGNED", 32'(al1), 32'd1);
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
